// File: rtl/adder_if.sv
// Operand/result bundle for the registered adder.
// The master drives operands and carry-in; the slave returns the registered sum.
interface adder_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] s;
    logic             cout;

    modport master (
        output a,
        output b,
        output cin,
        input  s,
        input  cout
    );

    modport slave (
        input  a,
        input  b,
        input  cin,
        output s,
        output cout
    );
endinterface

// File: rtl/adder.sv
// Registered unsigned adder: {cout, s} = a + b + cin one clock after sampling.
// The sum is built from 4-bit carry-lookahead groups chained through group generate/propagate.
module adder #(
    parameter int WIDTH = 32
) (
    input  logic   clk,
    input  logic   rst,
    adder_if.slave bus
);

    localparam int NG = (WIDTH + 3) / 4;
    localparam int PW = NG * 4;

    logic [PW-1:0]     a_ext;
    logic [PW-1:0]     b_ext;
    logic [PW:0]       res_ext;
    logic [PW-WIDTH:0] unused_hi;
    logic [WIDTH-1:0]  s_q;
    logic              cout_q;

    // Zero-padding the top group keeps p = g = 0 above the MSB, so the carry into
    // bit WIDTH lands in res_ext[WIDTH] unchanged.
    assign a_ext = PW'(bus.a);
    assign b_ext = PW'(bus.b);

    always_comb begin : cla
        logic [3:0] g;
        logic [3:0] p;
        logic [3:0] c;
        logic       grp_g;
        logic       grp_p;
        logic       grp_c;

        // NOTE: every variable gets a value before any branch or loop so no latch is inferred.
        res_ext = '0;
        g       = '0;
        p       = '0;
        c       = '0;
        grp_g   = 1'b0;
        grp_p   = 1'b0;
        grp_c   = bus.cin;

        for (int j = 0; j < NG; j++) begin
            g = a_ext[4*j +: 4] & b_ext[4*j +: 4];
            p = a_ext[4*j +: 4] ^ b_ext[4*j +: 4];

            c[0] = grp_c;
            c[1] = g[0] | (p[0] & grp_c);
            c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & grp_c);
            c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                 | (p[2] & p[1] & p[0] & grp_c);

            grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                  | (p[3] & p[2] & p[1] & g[0]);
            grp_p = &p;

            res_ext[4*j +: 4] = p ^ c;
            grp_c             = grp_g | (grp_p & grp_c);
        end

        res_ext[PW] = grp_c;
    end

    // Padding bits above the carry are always zero and intentionally unused.
    assign unused_hi = res_ext[PW:WIDTH];

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_q    <= '0;
            cout_q <= 1'b0;
        end else begin
            s_q    <= res_ext[WIDTH-1:0];
            cout_q <= res_ext[WIDTH];
        end
    end

    assign bus.s    = s_q;
    assign bus.cout = cout_q;

endmodule

// File: tb/tb_adder.sv
// Directed and random checks of the registered adder at WIDTH 32, 5 and 1.
// Expected values are hand-computed constants or the bench's own behavioural sum.
module tb_adder;

    logic clk;
    logic rst;

    int vectors;
    int miscompares;

    adder_if #(.WIDTH(32)) if32 ();
    adder_if #(.WIDTH(5))  if5  ();
    adder_if #(.WIDTH(1))  if1  ();

    adder #(.WIDTH(32)) u_add32 (.clk(clk), .rst(rst), .bus(if32));
    adder #(.WIDTH(5))  u_add5  (.clk(clk), .rst(rst), .bus(if5));
    adder #(.WIDTH(1))  u_add1  (.clk(clk), .rst(rst), .bus(if1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [64:0] observed, input logic [64:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic drive32(input logic [31:0] a, input logic [31:0] b, input logic cin);
        if32.a   = a;
        if32.b   = b;
        if32.cin = cin;
    endtask

    function automatic logic [64:0] obs32();
        return 65'({if32.cout, if32.s});
    endfunction

    function automatic logic [64:0] obs5();
        return 65'({if5.cout, if5.s});
    endfunction

    function automatic logic [64:0] obs1();
        return 65'({if1.cout, if1.s});
    endfunction

    initial begin
        logic [31:0] ra32, rb32;
        logic [4:0]  ra5, rb5;
        logic        ra1, rb1;
        logic        rc32, rc5, rc1;
        logic [32:0] e32;
        logic [5:0]  e5;
        logic [1:0]  e1;

        vectors     = 0;
        miscompares = 0;

        // Reset with all-ones operands: reset wins over the sampled inputs.
        rst = 1'b1;
        drive32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        if5.a = 5'h1F; if5.b = 5'h1F; if5.cin = 1'b1;
        if1.a = 1'b1;  if1.b = 1'b1;  if1.cin = 1'b1;
        tick();
        check("reset_w32", obs32(), 65'h0);
        check("reset_w5",  obs5(),  65'h0);
        check("reset_w1",  obs1(),  65'h0);

        // First edge with rst low samples normally.
        rst = 1'b0;
        if5.a = '0; if5.b = '0; if5.cin = 1'b0;
        if1.a = '0; if1.b = '0; if1.cin = 1'b0;
        drive32(32'h0000_0000, 32'h0000_0004, 1'b0);
        tick();
        check("v021", obs32(), 65'h0_0000_0004);

        drive32(32'h0000_0004, 32'h0000_0004, 1'b0);
        tick();
        check("v022", obs32(), 65'h0_0000_0008);

        drive32(32'h0000_0004, 32'h0000_F004, 1'b1);
        tick();
        check("v023", obs32(), 65'h0_0000_F009);

        drive32(32'hFFFF_FFFE, 32'h0000_0001, 1'b1);
        tick();
        check("v024_wrap", obs32(), 65'h1_0000_0000);

        drive32(32'h0000_000F, 32'h0000_0001, 1'b0);
        tick();
        check("group_carry", obs32(), 65'h0_0000_0010);

        drive32(32'h0FFF_FFFF, 32'h0000_0000, 1'b1);
        tick();
        check("long_propagate", obs32(), 65'h0_1000_0000);

        drive32(32'h8000_0000, 32'h8000_0000, 1'b0);
        tick();
        check("msb_carry", obs32(), 65'h1_0000_0000);

        drive32(32'h0000_0000, 32'h0000_0000, 1'b1);
        tick();
        check("cin_only", obs32(), 65'h0_0000_0001);

        drive32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        tick();
        check("v025_all_ones", obs32(), 65'h1_FFFF_FFFF);

        // Outputs must not follow input changes between edges.
        drive32(32'h0000_0001, 32'h0000_0001, 1'b0);
        #3;
        check("hold_between_edges", obs32(), 65'h1_FFFF_FFFF);

        // Mid-stream reset discards the operation sampled on that edge.
        rst = 1'b1;
        tick();
        check("midstream_reset", obs32(), 65'h0);

        rst = 1'b0;
        drive32(32'h1234_5678, 32'h1111_1111, 1'b0);
        tick();
        check("after_reset", obs32(), 65'h0_2345_6789);

        // Narrow widths, including the partial top group.
        if5.a = 5'h1F; if5.b = 5'h00; if5.cin = 1'b1;
        if1.a = 1'b1;  if1.b = 1'b1;  if1.cin = 1'b1;
        tick();
        check("w5_wrap_cin", obs5(), 65'h20);
        check("w1_all_ones", obs1(), 65'h3);

        if5.a = 5'h0F; if5.b = 5'h01; if5.cin = 1'b0;
        if1.a = 1'b1;  if1.b = 1'b0;  if1.cin = 1'b0;
        tick();
        check("w5_into_top_group", obs5(), 65'h10);
        check("w1_single",         obs1(), 65'h1);

        if5.a = 5'h10; if5.b = 5'h10; if5.cin = 1'b0;
        if1.a = 1'b0;  if1.b = 1'b0;  if1.cin = 1'b1;
        tick();
        check("w5_top_bit_carry", obs5(), 65'h20);
        check("w1_cin",           obs1(), 65'h1);

        // Back-to-back random operands on all three widths.
        for (int n = 0; n < 10000; n++) begin
            ra32 = $urandom;      rb32 = $urandom;      rc32 = 1'($urandom);
            ra5  = 5'($urandom);  rb5  = 5'($urandom);  rc5  = 1'($urandom);
            ra1  = 1'($urandom);  rb1  = 1'($urandom);  rc1  = 1'($urandom);
            drive32(ra32, rb32, rc32);
            if5.a = ra5; if5.b = rb5; if5.cin = rc5;
            if1.a = ra1; if1.b = rb1; if1.cin = rc1;
            e32 = 33'(ra32) + 33'(rb32) + 33'(rc32);
            e5  = 6'(ra5) + 6'(rb5) + 6'(rc5);
            e1  = 2'(ra1) + 2'(rb1) + 2'(rc1);
            tick();
            check("rand_w32", obs32(), 65'(e32));
            check("rand_w5",  obs5(),  65'(e5));
            check("rand_w1",  obs1(),  65'(e1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
